frame_addr_gen: RTL and testbench



---
 rtl/frame_addr_gen.sv | 161 ++++++++++++++++
 tb/tb_frame_addr_gen.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_addr_gen.sv
// Tags pixel beats with burst addresses walking a ring of frame buffers, skips the reader-held buffer, emits an end-of-frame status beat.
// Latency: zero-cycle data/ready pass-through in STREAM; status beat valid the cycle after the final burst beat.
// Backpressure: in_ready mirrors out_ready while streaming; the status beat holds out_valid until accepted.
module frame_addr_gen #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 64,
  parameter int                NUM_BUFS    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0F80_0000,
  parameter logic [ADDR_W-1:0] BUF_STRIDE  = 32'h0040_0000,
  parameter logic [ADDR_W-1:0] BUF_BYTES   = 32'h0040_0000,
  parameter int                BURST_LEN   = 16,
  parameter int                BEAT_BYTES  = 8,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 32'h1900_0000,
  localparam int               IDX_W       = $clog2(NUM_BUFS),
  localparam int               BC_W        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              hold_valid,
  input  logic [IDX_W-1:0]  hold_idx,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_addr_valid,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  cur_buf,
  output logic              overflow,
  output logic              seq_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_STATUS} state_t;

  localparam logic [ADDR_W:0]  STEP      = (ADDR_W+1)'(BURST_LEN * BEAT_BYTES);
  localparam logic [BC_W-1:0]  BEAT_LAST = BC_W'(BURST_LEN - 1);

  state_t            state;
  logic [IDX_W-1:0]  last_buf;
  logic [ADDR_W-1:0] offset;
  logic [BC_W-1:0]   beat_cnt;
  logic [15:0]       burst_cnt;
  logic              end_pend;

  logic              xfer;
  logic              last_beat;
  logic [ADDR_W:0]   off_sum;
  logic              off_wrap;
  logic [IDX_W-1:0]  ring_nxt;
  logic [IDX_W-1:0]  nxt_buf;

  function automatic logic [ADDR_W-1:0] buf_base(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * BUF_STRIDE;
  endfunction

  function automatic logic [IDX_W-1:0] ring_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_BUFS - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Transfer qualification, offset advance/wrap and next-buffer selection around a held buffer
  always_comb begin
    xfer      = (state == ST_STREAM) && in_valid && out_ready;
    last_beat = (beat_cnt == BEAT_LAST);
    off_sum   = {1'b0, offset} + STEP;
    off_wrap  = (off_sum >= {1'b0, BUF_BYTES});
    ring_nxt  = ring_inc(last_buf);
    nxt_buf   = (hold_valid && (hold_idx == ring_nxt)) ? ring_inc(ring_nxt) : ring_nxt;
  end

  // Output mux: idle, combinational pass-through, or the fixed-address status beat
  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_addr_valid = 1'b0;
    out_last       = 1'b0;
    out_data       = '0;
    out_addr       = buf_base(cur_buf) + offset;
    case (state)
      ST_STREAM: begin
        in_ready       = out_ready;
        out_valid      = in_valid;
        out_data       = in_data;
        out_addr_valid = in_valid && (beat_cnt == '0);
        out_last       = in_valid && last_beat;
      end
      ST_STATUS: begin
        out_valid                  = 1'b1;
        out_addr                   = STATUS_ADDR;
        out_addr_valid             = 1'b1;
        out_last                   = 1'b1;
        out_data[ADDR_W-1:0]       = buf_base(cur_buf);
        out_data[ADDR_W+15:ADDR_W] = burst_cnt;
      end
      default: ;
    endcase
  end

  // Frame sequencing, beat/burst counting, wrap and error flags
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      cur_buf   <= '0;
      last_buf  <= IDX_W'(NUM_BUFS - 1);
      offset    <= '0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      end_pend  <= 1'b0;
      overflow  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            cur_buf   <= nxt_buf;
            offset    <= '0;
            beat_cnt  <= '0;
            burst_cnt <= '0;
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (frame_start) seq_err <= 1'b1;
          if (xfer) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + BC_W'(1);
            if (last_beat) begin
              if (burst_cnt != 16'hFFFF) burst_cnt <= burst_cnt + 16'd1;
              if (off_wrap) begin
                offset   <= '0;
                overflow <= 1'b1;
              end else begin
                offset <= off_sum[ADDR_W-1:0];
              end
            end
          end
          // Bursts always complete; an end request mid-burst waits for the last beat
          if (xfer && last_beat && (end_pend || frame_end)) begin
            state <= ST_STATUS;
          end else if (frame_end && (beat_cnt == '0) && !xfer) begin
            state <= ST_STATUS;
          end else if (frame_end) begin
            end_pend <= 1'b1;
          end
        end
        ST_STATUS: begin
          if (frame_start) seq_err <= 1'b1;
          if (out_ready) begin
            last_buf <= cur_buf;
            end_pend <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_addr_gen.sv
// Self-checking bench for frame_addr_gen with a 256-byte buffer so wrap is reachable.
// Expected beats are queued as they are driven and compared when the DUT transfers them.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_frame_addr_gen;

  localparam logic [31:0] BASE   = 32'h0F80_0000;
  localparam logic [31:0] STRIDE = 32'h0040_0000;
  localparam logic [31:0] STAT   = 32'h1900_0000;
  localparam int          BUFB   = 256;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        frame_start, frame_end, hold_valid;
  logic [1:0]  hold_idx;
  logic [63:0] in_data;
  logic        in_valid, in_ready;
  logic [63:0] out_data;
  logic [31:0] out_addr;
  logic        out_addr_valid, out_last, out_valid, out_ready;
  logic [1:0]  cur_buf;
  logic        overflow, seq_err;

  always #5 sys_clk = ~sys_clk;

  frame_addr_gen #(.BUF_BYTES(32'h0000_0100)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .frame_start(frame_start), .frame_end(frame_end),
    .hold_valid(hold_valid), .hold_idx(hold_idx), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_addr(out_addr), .out_addr_valid(out_addr_valid),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .cur_buf(cur_buf),
    .overflow(overflow), .seq_err(seq_err)
  );

  typedef struct packed {
    logic        av;
    logic [31:0] addr;
    logic        last;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_base, m_off;
  int          m_beat, m_bursts;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_beat(input logic [63:0] d);
    exp_t e;
    e.av   = (m_beat == 0);
    e.addr = m_base + m_off;
    e.last = (m_beat == 15);
    e.data = d;
    exp_q.push_back(e);
    m_beat++;
    if (m_beat == 16) begin
      m_beat = 0;
      m_bursts++;
      m_off += 128;
      if (m_off >= BUFB) m_off = 0;
    end
  endtask

  task automatic push_status();
    exp_t e;
    e.av   = 1'b1;
    e.addr = STAT;
    e.last = 1'b1;
    e.data = {16'h0, 16'(m_bursts), m_base};
    exp_q.push_back(e);
  endtask

  task automatic drive_beats(input int n);
    for (int i = 0; i < n; i++) begin
      logic [63:0] d;
      d        = {$urandom, $urandom};
      in_data  = d;
      in_valid = 1'b1;
      push_beat(d);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic start_frame(input int idx);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_base   = BASE + idx * STRIDE;
    m_off    = 0;
    m_beat   = 0;
    m_bursts = 0;
    vectors++;
    if (cur_buf !== 2'(idx)) begin
      miscompares++;
      $display("FAIL start_cur_buf: got %0d, need %0d", cur_buf, idx);
    end
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    push_status();
    tick();
  endtask

  // Scoreboard: every accepted output beat must match the oldest queued expectation
  always @(negedge sys_clk) begin
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got addr %h data %h, none expected", out_addr, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_addr_valid, out_addr, out_last, out_data} !== e) begin
          miscompares++;
          $display("FAIL beat: got av=%b addr=%h last=%b data=%h, need av=%b addr=%h last=%b data=%h",
                   out_addr_valid, out_addr, out_last, out_data, e.av, e.addr, e.last, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    exp_q.delete();
    @(negedge sys_clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_addr_valid !== 1'b0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: got in_ready=%b out_valid=%b av=%b last=%b, need all 0",
               in_ready, out_valid, out_addr_valid, out_last);
    end
    vectors++;
    if (out_data !== 64'h0 || out_addr !== BASE) begin
      miscompares++;
      $display("FAIL reset_bus: got data=%h addr=%h, need 0 and %h", out_data, out_addr, BASE);
    end
    vectors++;
    if (cur_buf !== 2'd0 || overflow !== 1'b0 || seq_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: got cur_buf=%0d ovf=%b seq=%b, need 0 0 0", cur_buf, overflow, seq_err);
    end
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_basic();
    test_reset();
    start_frame(0);
    vectors++;
    if (out_addr !== 32'h0F80_0000) begin
      miscompares++;
      $display("FAIL basic_first_addr: got %h, need 0f800000", out_addr);
    end
    drive_beats(32);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    push_status();
    @(negedge sys_clk);
    vectors++;
    if (out_addr !== 32'h1900_0000 || out_data !== 64'h0000_0002_0F80_0000 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_status: got addr=%h data=%h in_ready=%b, need 19000000 00000002_0f800000 0",
               out_addr, out_data, in_ready);
    end
    tick();
    vectors++;
    if (cur_buf !== 2'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: got cur_buf=%0d out_valid=%b, need 0 0", cur_buf, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d7;
    start_frame(1);
    drive_beats(7);
    d7       = {$urandom, $urandom};
    in_data  = d7;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      vectors++;
      if (in_ready !== 1'b0 || out_addr !== 32'h0FC0_0000 || out_addr_valid !== 1'b0 || out_last !== 1'b0) begin
        miscompares++;
        $display("FAIL stall: got in_ready=%b addr=%h av=%b last=%b, need 0 0fc00000 0 0",
                 in_ready, out_addr, out_addr_valid, out_last);
      end
      tick();
    end
    out_ready = 1'b1;
    push_beat(d7);
    tick();
    drive_beats(8);
    end_frame();
  endtask

  task automatic test_ring();
    int order[5] = '{0, 1, 2, 3, 0};
    test_reset();
    foreach (order[i]) begin
      start_frame(order[i]);
      drive_beats(16);
      end_frame();
    end
    hold_valid = 1'b1;
    hold_idx   = 2'd1;
    start_frame(2);
    hold_valid = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if (out_addr !== 32'h1000_0000) begin
      miscompares++;
      $display("FAIL hold_skip_addr: got %h, need 10000000", out_addr);
    end
    tick();
    drive_beats(16);
    end_frame();
  endtask

  task automatic test_wrap();
    test_reset();
    start_frame(0);
    drive_beats(16);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_early: got overflow=%b, need 0", overflow);
    end
    drive_beats(16);
    @(negedge sys_clk);
    vectors++;
    if (overflow !== 1'b1 || out_addr !== 32'h0F80_0000) begin
      miscompares++;
      $display("FAIL wrap: got overflow=%b addr=%h, need 1 0f800000", overflow, out_addr);
    end
    tick();
    drive_beats(16);
    end_frame();
    start_frame(1);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_sticky: got overflow=%b, need 1", overflow);
    end
    drive_beats(16);
    end_frame();
  endtask

  task automatic test_early_end_and_seq();
    logic [63:0] d;
    test_reset();
    start_frame(0);
    drive_beats(5);
    d         = {$urandom, $urandom};
    in_data   = d;
    in_valid  = 1'b1;
    frame_end = 1'b1;
    push_beat(d);
    tick();
    frame_end = 1'b0;
    drive_beats(10);
    push_status();
    @(negedge sys_clk);
    vectors++;
    if (out_valid !== 1'b1 || out_addr !== STAT || out_data[47:32] !== 16'd1) begin
      miscompares++;
      $display("FAIL early_end_status: got valid=%b addr=%h bursts=%0d, need 1 %h 1",
               out_valid, out_addr, out_data[47:32], STAT);
    end
    tick();
    start_frame(1);
    vectors++;
    if (seq_err !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_err_clean: got %b, need 0", seq_err);
    end
    drive_beats(3);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    vectors++;
    if (seq_err !== 1'b1 || cur_buf !== 2'd1) begin
      miscompares++;
      $display("FAIL seq_err: got seq_err=%b cur_buf=%0d, need 1 1", seq_err, cur_buf);
    end
    drive_beats(13);
    end_frame();
  endtask

  task automatic test_reset_mid_frame();
    test_reset();
    start_frame(0); drive_beats(16); end_frame();
    start_frame(1); drive_beats(16); end_frame();
    start_frame(2);
    drive_beats(20);
    sys_rst = 1'b1;
    tick();
    sys_rst  = 1'b0;
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0000_0001;
    @(negedge sys_clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: got in_ready=%b out_valid=%b, need 0 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_pending: got %0d queued beats, need 0", exp_q.size());
    end
    start_frame(0);
    drive_beats(16);
    end_frame();
  endtask

  initial begin
    sys_rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0; hold_valid = 1'b0; hold_idx = 2'd0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    m_base = BASE; m_off = 0; m_beat = 0; m_bursts = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ring();
    test_wrap();
    test_early_end_and_seq();
    test_reset_mid_frame();
    tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d beats never produced, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
